// File: rtl/aes_round_scheduler_pkg.sv
// Shared types and constants for the iterative AES round scheduler.
package aes_round_scheduler_pkg;

   localparam int BLK_W = 128;
   localparam int CNT_W = 4;

   typedef enum logic [2:0] {
      NOKEY = 3'd0,
      KRST  = 3'd1,
      KEXP  = 3'd2,
      READY = 3'd3,
      ROUND = 3'd4,
      OUT   = 3'd5
   } sched_state_t;

   // AES ties the round count to the key length.
   function automatic int nr_of(input int nk);
      return nk + 6;
   endfunction

endpackage

// File: rtl/aes_round_scheduler_if.sv
// Block request/result handshake between a data source/sink and the scheduler.
interface aes_round_scheduler_if;
   import aes_round_scheduler_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic             in_dec;
   logic [BLK_W-1:0] in_block;
   logic             out_valid;
   logic             out_ready;
   logic [BLK_W-1:0] out_block;

   modport master (
      output in_valid, in_dec, in_block, out_ready,
      input  in_ready, out_valid, out_block
   );

   modport slave (
      input  in_valid, in_dec, in_block, out_ready,
      output in_ready, out_valid, out_block
   );

endinterface

// File: rtl/aes_round_scheduler_rk_select.sv
// Picks round key idx out of the packed expanded schedule (round 0 in the MSBs).
module aes_round_scheduler_rk_select
   import aes_round_scheduler_pkg::*;
#(
   parameter int NR = 10
) (
   input  logic [(NR+1)*BLK_W-1:0] sched,
   input  logic [CNT_W-1:0]        idx,
   output logic [BLK_W-1:0]        rk
);

   // (NR+1)-way mux; indices above NR never occur and return zero.
   always_comb begin
      rk = '0;
      for (int r = 0; r <= NR; r++) begin
         if (idx == CNT_W'(r)) rk = sched[(NR+1)*BLK_W-1-BLK_W*r -: BLK_W];
      end
   end

endmodule

// File: rtl/aes_round_scheduler.sv
// Sequencer for the iterative AES core: owns the key register, drives KeyExpansion
// and streams one block at a time through an external one-round-per-cycle unit.
//
// state | meaning
// NOKEY | no valid key; waiting for key_load
// KRST  | one cycle holding KeyExpansion in reset with the new key
// KEXP  | KeyExpansion enabled, waiting for ke_done
// READY | schedule valid; accepts a block or a new key (key wins)
// ROUND | one round per cycle, cnt = 1..Nr
// OUT   | result held until out_ready
module aes_round_scheduler
   import aes_round_scheduler_pkg::*;
#(
   parameter int Nk = 4,
   parameter int Nr = 10
) (
   input  logic                      clk,
   input  logic                      rst,
   aes_round_scheduler_if.slave      bus,
   input  logic                      key_load,
   input  logic [Nk*32-1:0]          key_in,
   output logic                      key_ready,
   output logic                      ke_rst,
   output logic                      ke_en,
   output logic [Nk*32-1:0]          ke_key,
   input  logic                      ke_done,
   input  logic [(Nr+1)*BLK_W-1:0]   ke_sched,
   output logic [BLK_W-1:0]          rnd_state,
   output logic [BLK_W-1:0]          rnd_key,
   output logic                      rnd_final,
   output logic                      rnd_dec,
   input  logic [BLK_W-1:0]          rnd_out
);

   if (Nr != nr_of(Nk) || Nr > 14) begin : g_bad_nr
      $error("aes_round_scheduler: Nr must equal Nk+6 and fit the 4-bit round counter");
   end

   localparam logic [CNT_W-1:0] NR_C = CNT_W'(Nr);

   sched_state_t     state;
   logic [BLK_W-1:0] state_reg;
   logic             dec_r;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] rk_idx;
   logic [BLK_W-1:0] rk;
   logic             accept;

   assign bus.in_ready = (state == READY) && !key_load;
   assign accept       = bus.in_valid && bus.in_ready;

   // In READY the mux serves the initial AddRoundKey of the incoming block; otherwise the current round.
   always_comb begin
      rk_idx = '0;
      if (state == READY) rk_idx = bus.in_dec ? NR_C : '0;
      else                rk_idx = dec_r ? (NR_C - cnt) : cnt;
   end

   aes_round_scheduler_rk_select #(.NR(Nr)) u_rk_select (
      .sched (ke_sched),
      .idx   (rk_idx),
      .rk    (rk)
   );

   assign rnd_state = state_reg;
   assign rnd_key   = rk;
   assign rnd_dec   = dec_r;
   assign rnd_final = (cnt == NR_C);

   // Main FSM with registered handshake and KeyExpansion controls.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= NOKEY;
         key_ready     <= 1'b0;
         ke_en         <= 1'b0;
         ke_rst        <= 1'b1;
         ke_key        <= '0;
         bus.out_valid <= 1'b0;
         bus.out_block <= '0;
         state_reg     <= '0;
         dec_r         <= 1'b0;
         cnt           <= '0;
      end else begin
         case (state)
            NOKEY: begin
               if (key_load) begin
                  ke_key <= key_in;
                  state  <= KRST;
               end
            end
            KRST: begin
               ke_rst <= 1'b0;
               ke_en  <= 1'b1;
               state  <= KEXP;
            end
            KEXP: begin
               if (ke_done) begin
                  ke_en     <= 1'b0;
                  key_ready <= 1'b1;
                  state     <= READY;
               end
            end
            READY: begin
               if (key_load) begin
                  key_ready <= 1'b0;
                  ke_key    <= key_in;
                  ke_rst    <= 1'b1;
                  state     <= KRST;
               end else if (accept) begin
                  dec_r     <= bus.in_dec;
                  state_reg <= bus.in_block ^ rk;
                  cnt       <= CNT_W'(1);
                  state     <= ROUND;
               end
            end
            ROUND: begin
               state_reg <= rnd_out;
               cnt       <= cnt + CNT_W'(1);
               if (cnt == NR_C) begin
                  bus.out_block <= rnd_out;
                  bus.out_valid <= 1'b1;
                  state         <= OUT;
               end
            end
            OUT: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  state         <= READY;
               end
            end
            default: state <= NOKEY;
         endcase
      end
   end

endmodule
